// File: rtl/tuple_merge2_if.sv
// Tuple stream bundle: two upstream inputs plus one merged output.
// Field names mirror the tuple fields carried end to end.
interface tuple_merge2_if #(
  parameter int INPUT_SIZE = 64
);
  logic [1:0]                 in_valid;
  logic [1:0]                 in_ready;
  logic [1:0][INPUT_SIZE-1:0] in_data;
  logic [1:0][31:0]           in_tag;
  logic [1:0]                 in_last_processed;
  logic [1:0][63:0]           in_serialnum;
  logic [1:0]                 in_was_joined;
  logic                       out_ready;
  logic                       out_valid;
  logic [INPUT_SIZE-1:0]      out_data;
  logic [31:0]                out_tag;
  logic                       out_last_processed;
  logic [63:0]                out_serialnum;
  logic                       out_was_joined;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_tag,
    input  in_last_processed,
    input  in_serialnum,
    input  in_was_joined,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_tag,
    output out_last_processed,
    output out_serialnum,
    output out_was_joined
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_tag,
    output in_last_processed,
    output in_serialnum,
    output in_was_joined,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_tag,
    input  out_last_processed,
    input  out_serialnum,
    input  out_was_joined
  );
endinterface

// File: rtl/tuple_merge2.sv
// Two-way round-robin tuple merge with a single output register.
// The stream ends only once both inputs have delivered their last tuple.
module tuple_merge2 #(
  parameter int INPUT_SIZE = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  tuple_merge2_if.slave        bus,
  output logic [CNT_WIDTH-1:0] tuple_count
);

  logic [1:0] done_q;
  logic       prio_q;

  logic       v_eff;
  logic       prio_eff;
  logic [1:0] done_eff;
  logic       load_ok;
  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] rdy;
  logic       hs;
  logic       sel;
  logic       end_acc;
  logic       out_acc;
  logic [1:0] done_nx;

  logic [INPUT_SIZE-1:0] sel_data;

  // While in reset the handshake logic sees the post-reset state
  assign v_eff    = resetn & bus.out_valid;
  assign prio_eff = resetn & prio_q;
  assign done_eff = resetn ? done_q : 2'b00;

  assign load_ok = ~v_eff | bus.out_ready;
  assign elig    = bus.in_valid & ~done_eff;

  always_comb begin
    grant = 2'b00;
    if (elig[prio_eff]) begin
      grant[prio_eff] = 1'b1;
    end else if (elig[~prio_eff]) begin
      grant[~prio_eff] = 1'b1;
    end
  end

  assign rdy          = {2{load_ok}} & grant & ~done_eff;
  assign bus.in_ready = rdy;

  assign hs       = |(bus.in_valid & rdy);
  assign sel      = rdy[1];
  assign sel_data = bus.in_data[sel];

  assign out_acc = bus.out_valid & bus.out_ready;
  assign end_acc = out_acc & bus.out_last_processed;

  always_comb begin
    done_nx = done_q;
    if (hs) begin
      done_nx[sel] = done_q[sel]
                   | bus.in_last_processed[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.out_valid          <= 1'b0;
      bus.out_data           <= '0;
      bus.out_tag            <= '0;
      bus.out_last_processed <= 1'b0;
      bus.out_serialnum      <= '0;
      bus.out_was_joined     <= 1'b0;
      done_q                 <= 2'b00;
      prio_q                 <= 1'b0;
      tuple_count            <= '0;
    end else begin
      if (hs) begin
        bus.out_valid          <= 1'b1;
        bus.out_data           <= sel_data;
        bus.out_tag            <= bus.in_tag[sel];
        bus.out_serialnum      <= bus.in_serialnum[sel];
        bus.out_was_joined     <= bus.in_was_joined[sel];
        bus.out_last_processed <= &done_nx;
        prio_q                 <= ~sel;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      // Both flags are set while a stream end is pending, so no
      // handshake can collide with the clear below.
      if (end_acc) begin
        done_q      <= 2'b00;
        prio_q      <= 1'b0;
        tuple_count <= '0;
      end else begin
        done_q <= done_nx;
        if (out_acc) begin
          tuple_count <= tuple_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tuple_merge2.sv
// Bench for tuple_merge2: directed stimulus, per-cycle model compare
// and hand-computed literal expectations.
module tb_tuple_merge2;

  localparam int CW = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] tag;
    logic        last;
    logic [63:0] ser;
    logic        wj;
  } tup_t;

  logic          clk;
  logic          resetn;
  logic [CW-1:0] tuple_count;

  tuple_merge2_if #(.INPUT_SIZE(64)) b();

  tuple_merge2 #(
    .INPUT_SIZE(64),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (b),
    .tuple_count(tuple_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  bit armed;

  tup_t src0[$];
  tup_t src1[$];
  logic [63:0] acc_ser[$];
  logic        acc_last[$];

  bit          m_valid;
  logic [63:0] m_data;
  logic [31:0] m_tag;
  bit          m_last;
  logic [63:0] m_ser;
  bit          m_wj;
  bit [1:0]    m_done;
  bit          m_prio;
  int          m_cnt;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, req, $time);
    end
  endtask

  function automatic tup_t mk(input logic [63:0] ser,
                              input logic [31:0] tag,
                              input logic last,
                              input logic wj);
    tup_t t;
    t.data = {ser[31:0], ~ser[31:0]};
    t.tag  = tag;
    t.last = last;
    t.ser  = ser;
    t.wj   = wj;
    return t;
  endfunction

  task automatic drive();
    tup_t t0;
    tup_t t1;
    t0 = '0;
    t1 = '0;
    if (src0.size() > 0) t0 = src0[0];
    if (src1.size() > 0) t1 = src1[0];
    b.in_valid[0]          = src0.size() > 0;
    b.in_valid[1]          = src1.size() > 0;
    b.in_data[0]           = t0.data;
    b.in_data[1]           = t1.data;
    b.in_tag[0]            = t0.tag;
    b.in_tag[1]            = t1.tag;
    b.in_last_processed[0] = t0.last;
    b.in_last_processed[1] = t1.last;
    b.in_serialnum[0]      = t0.ser;
    b.in_serialnum[1]      = t1.ser;
    b.in_was_joined[0]     = t0.wj;
    b.in_was_joined[1]     = t1.wj;
  endtask

  // Expected accept vector: round robin over inputs not yet done
  function automatic logic [1:0] exp_ready();
    bit v;
    bit p;
    bit [1:0] dn;
    bit [1:0] e;
    v  = resetn ? m_valid : 1'b0;
    p  = resetn ? m_prio : 1'b0;
    dn = resetn ? m_done : 2'b00;
    if (v && !b.out_ready) return 2'b00;
    e = b.in_valid & ~dn;
    if (e[p]) return p ? 2'b10 : 2'b01;
    if (e[!p]) return p ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_tag   = '0;
    m_last  = 0;
    m_ser   = '0;
    m_wj    = 0;
    m_done  = 2'b00;
    m_prio  = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    logic [1:0] r;
    int i;
    bit ea;
    if (!resetn) begin
      model_reset();
    end else begin
      r  = exp_ready();
      ea = m_valid && b.out_ready && m_last;
      if (m_valid && b.out_ready)
        m_cnt = ea ? 0 : (m_cnt + 1) % (1 << CW);
      if (r != 2'b00) begin
        i       = r[1] ? 1 : 0;
        m_valid = 1;
        m_data  = b.in_data[i];
        m_tag   = b.in_tag[i];
        m_ser   = b.in_serialnum[i];
        m_wj    = b.in_was_joined[i];
        m_prio  = (i == 0);
        if (b.in_last_processed[i]) m_done[i] = 1'b1;
        m_last  = m_done[0] && m_done[1];
      end else if (b.out_ready) begin
        m_valid = 0;
      end
      if (ea) begin
        m_done = 2'b00;
        m_prio = 0;
      end
    end
  endtask

  task automatic compare();
    chk("in_ready", 64'(b.in_ready), 64'(exp_ready()));
    chk("out_valid", 64'(b.out_valid), 64'(m_valid));
    chk("tuple_count", 64'(tuple_count), 64'(m_cnt));
    if (m_valid) begin
      chk("out_data", b.out_data, m_data);
      chk("out_tag", 64'(b.out_tag), 64'(m_tag));
      chk("out_serialnum", b.out_serialnum, m_ser);
      chk("out_last", 64'(b.out_last_processed),
          64'(m_last));
      chk("out_was_joined", 64'(b.out_was_joined),
          64'(m_wj));
    end
  endtask

  task automatic cycle();
    bit hs0;
    bit hs1;
    @(negedge clk);
    if (armed) compare();
    hs0 = b.in_valid[0] && b.in_ready[0];
    hs1 = b.in_valid[1] && b.in_ready[1];
    if (resetn && b.out_valid && b.out_ready) begin
      acc_ser.push_back(b.out_serialnum);
      acc_last.push_back(b.out_last_processed);
    end
    @(posedge clk);
    model_step();
    armed = 1;
    #1;
    if (hs0) void'(src0.pop_front());
    if (hs1) void'(src1.pop_front());
    drive();
  endtask

  logic [15:0] rdy_pat;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    armed  = 0;
    model_reset();
    resetn      = 0;
    b.out_ready = 1;
    drive();
    cycle();
    cycle();
    #1;
    chk("rst_valid", 64'(b.out_valid), 0);
    chk("rst_count", 64'(tuple_count), 0);
    chk("rst_data", b.out_data, 0);
    chk("rst_tag", 64'(b.out_tag), 0);
    chk("rst_ser", b.out_serialnum, 0);
    chk("rst_last", 64'(b.out_last_processed), 0);
    chk("rst_wj", 64'(b.out_was_joined), 0);
    resetn = 1;

    // Alternating full-throughput merge
    src0.push_back(mk(64'hA0, 32'h100, 0, 1));
    src0.push_back(mk(64'hA1, 32'h101, 0, 0));
    src1.push_back(mk(64'hB0, 32'h200, 0, 0));
    src1.push_back(mk(64'hB1, 32'h201, 0, 1));
    acc_ser.delete();
    acc_last.delete();
    drive();
    repeat (6) cycle();
    chk("alt_n", 64'(acc_ser.size()), 4);
    if (acc_ser.size() == 4) begin
      chk("alt_0", acc_ser[0], 64'hA0);
      chk("alt_1", acc_ser[1], 64'hB0);
      chk("alt_2", acc_ser[2], 64'hA1);
      chk("alt_3", acc_ser[3], 64'hB1);
    end
    chk("alt_count", 64'(tuple_count), 4);

    // Backpressure hold, then load without a bubble
    src0.push_back(mk(64'h30, 32'h11, 0, 0));
    drive();
    cycle();
    b.out_ready = 0;
    src1.push_back(mk(64'h31, 32'h22, 0, 1));
    drive();
    repeat (3) begin
      #1;
      chk("hold_rdy", 64'(b.in_ready), 0);
      chk("hold_tag", 64'(b.out_tag), 64'h11);
      chk("hold_vld", 64'(b.out_valid), 1);
      cycle();
    end
    b.out_ready = 1;
    #1;
    chk("rel_rdy", 64'(b.in_ready), 64'h2);
    cycle();
    chk("rel_tag", 64'(b.out_tag), 64'h22);
    chk("rel_vld", 64'(b.out_valid), 1);
    cycle();
    cycle();

    // Stream end: input 0 finishes first
    src0.push_back(mk(64'h5, 32'h5, 1, 0));
    src0.push_back(mk(64'h9, 32'h9, 0, 0));
    src1.push_back(mk(64'h7, 32'h7, 0, 1));
    src1.push_back(mk(64'h8, 32'h8, 1, 0));
    acc_ser.delete();
    acc_last.delete();
    drive();
    cycle();
    #1;
    chk("end_rdy1", 64'(b.in_ready), 64'h2);
    chk("end_last5", 64'(b.out_last_processed), 0);
    cycle();
    #1;
    chk("end_rdy0", 64'(b.in_ready[0]), 0);
    cycle();
    #1;
    chk("end_rdy_both", 64'(b.in_ready), 0);
    chk("end_last8", 64'(b.out_last_processed), 1);
    cycle();
    chk("end_count", 64'(tuple_count), 0);
    chk("end_vld", 64'(b.out_valid), 0);
    cycle();
    cycle();
    chk("end_count1", 64'(tuple_count), 1);
    chk("end_n", 64'(acc_ser.size()), 4);
    if (acc_ser.size() == 4) begin
      chk("end_s0", acc_ser[0], 64'h5);
      chk("end_s1", acc_ser[1], 64'h7);
      chk("end_s2", acc_ser[2], 64'h8);
      chk("end_l2", 64'(acc_last[2]), 1);
      chk("end_s3", acc_ser[3], 64'h9);
    end

    // Lone input 1 while priority points at input 0
    src1.push_back(mk(64'h40, 32'h40, 0, 0));
    drive();
    cycle();
    cycle();
    src1.push_back(mk(64'h41, 32'h41, 0, 0));
    drive();
    #1;
    chk("lone_rdy", 64'(b.in_ready), 64'h2);
    cycle();
    src0.push_back(mk(64'h50, 32'h50, 0, 1));
    src1.push_back(mk(64'h51, 32'h51, 0, 0));
    drive();
    #1;
    chk("lone_prio", 64'(b.in_ready), 64'h1);
    repeat (3) cycle();

    // Reset while a tuple is held and input 0 is done
    b.out_ready = 0;
    src0.push_back(mk(64'h60, 32'h60, 1, 0));
    drive();
    cycle();
    #1;
    chk("rst2_vld", 64'(b.out_valid), 1);
    resetn = 0;
    src1.push_back(mk(64'h61, 32'h61, 0, 0));
    drive();
    #1;
    chk("rst2_rdy", 64'(b.in_ready), 64'h2);
    cycle();
    chk("rst2_vld0", 64'(b.out_valid), 0);
    chk("rst2_count", 64'(tuple_count), 0);
    resetn      = 1;
    b.out_ready = 1;
    src0.push_back(mk(64'h62, 32'h62, 0, 0));
    drive();
    #1;
    chk("rst2_rdy0", 64'(b.in_ready), 64'h1);
    cycle();
    cycle();

    // Counter wrap after 16 accepted tuples
    resetn = 0;
    drive();
    cycle();
    resetn = 1;
    for (int k = 0; k < 8; k++) begin
      src0.push_back(mk(64'h100 + k, 32'(k), 0, 0));
      src1.push_back(mk(64'h180 + k, 32'(k), 0, 1));
    end
    acc_ser.delete();
    acc_last.delete();
    drive();
    repeat (16) cycle();
    chk("wrap_15", 64'(tuple_count), 64'hF);
    cycle();
    chk("wrap_0", 64'(tuple_count), 0);
    chk("wrap_n", 64'(acc_ser.size()), 16);

    // Mixed backpressure and stream ends
    rdy_pat = 16'b1011_0110_1110_0101;
    for (int k = 0; k < 12; k++) begin
      src0.push_back(mk(64'h200 + k, 32'h20 + k,
                        (k == 5) || (k == 11), k[0]));
      src1.push_back(mk(64'h300 + k, 32'h30 + k,
                        (k == 8), k[1]));
    end
    drive();
    for (int c = 0; c < 60; c++) begin
      b.out_ready = rdy_pat[c % 16];
      drive();
      cycle();
    end
    b.out_ready = 1;
    drive();
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tuple_merge2.md
TUPLE_MERGE2 -- requirements
Module: tuple_merge2

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 64, tuple payload width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of the merged-tuple counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  [1:0]  per-input tuple valid.
REQ-006 SHALL have port in_ready  output  [1:0]  per-input accept.
REQ-007 SHALL have port in_data  input  [1:0][INPUT_SIZE-1:0]  tuple payload.
REQ-008 SHALL have port in_tag  input  [1:0][31:0]  tuple tag.
REQ-009 SHALL have port in_last_processed  input  [1:0]  final tuple of that input's stream.
REQ-010 SHALL have port in_serialnum  input  [1:0][63:0]  tuple serial number.
REQ-011 SHALL have port in_was_joined  input  [1:0]  join-hit flag.
REQ-012 SHALL have port out_ready  input  1  downstream accept.
REQ-013 SHALL have ports out_valid (1), out_data (INPUT_SIZE), out_tag (32), out_last_processed (1), out_serialnum (64), out_was_joined (1), all outputs, merged tuple stream.
REQ-014 SHALL have port tuple_count  output  CNT_WIDTH  tuples accepted downstream since reset or since the last stream end.

Function
REQ-015 SHALL merge two tuple streams, as produced by two-way hash distributor outputs, into one stream through a single output register stage. Latency is 1 cycle from input handshake to out_valid.
REQ-016 SHALL define load_ok = !out_valid | out_ready. A handshake on input i occurs when in_valid[i] & in_ready[i].
REQ-017 SHALL arbitrate round-robin with a 1-bit priority pointer prio (reset 0).
  - Eligible input = in_valid & !done.
  - Grant goes to input prio if eligible, else to the other input if eligible.
REQ-018 SHALL drive in_ready[i] = load_ok & grant[i] & !done[i]. At most one in_ready bit is high per cycle.
REQ-019 On a handshake on input i, SHALL load all tuple fields of input i into the output register, set out_valid=1, and set prio to the other input.
REQ-020 With no handshake and out_ready=1, SHALL clear out_valid. With out_ready=0, SHALL hold all output fields stable.
REQ-021 SHALL keep per-input flags done[1:0] (reset 0). A handshake with in_last_processed[i]=1 sets done[i].
REQ-022 SHALL set out_last_processed=1 only on the tuple whose handshake completes both done flags. The first stream's last tuple is forwarded with out_last_processed=0.
REQ-023 When the stream-ending tuple (out_last_processed=1) is accepted downstream, SHALL clear both done flags, clear tuple_count to 0, and reset prio to 0 on the same edge.
REQ-024 SHALL pass tag, serialnum and was_joined unmodified from the granted input.
REQ-025 SHALL increment tuple_count on each out_valid & out_ready. The counter wraps modulo 2^CNT_WIDTH. Clearing per REQ-023 takes precedence over incrementing.
REQ-026 When both inputs are valid continuously and out_ready=1, SHALL alternate grants 0,1,0,1 with one tuple per cycle (full throughput).
REQ-027 A done input SHALL get in_ready=0. Its in_valid is ignored until the flags clear.

Reset
REQ-028 With resetn=0 at a rising edge, SHALL set the following, regardless of in-flight tuples:
  - out_valid=0, out_last_processed=0, out_was_joined=0
  - out_data=0, out_tag=0, out_serialnum=0
  - done=0, prio=0, tuple_count=0
REQ-029 During reset, in_ready SHALL evaluate from the reset state. A tuple presented in the reset cycle is dropped.

Verification
REQ-030 Both in_valid=1 for 4 cycles, out_ready=1, serialnums A0..A3 / B0..B3 -> output A0,B0,A1,B1 on consecutive cycles; tuple_count=4.
REQ-031 out_valid=1 holding tag 0x11, out_ready=0 for 3 cycles -> in_ready=2'b00, output fields unchanged; out_ready=1 -> next tuple loads the same cycle (no bubble).
REQ-032 Input 0 sends last (serial 5) while input 1 continues (serial 7, then last at serial 8):
  - serial 5 output with last=0
  - in_ready[0]=0 afterward
  - serial 8 output with last=1
  - tuple_count=0 one cycle after its acceptance
REQ-033 Only in_valid[1]=1 while prio=0 -> input 1 granted immediately; prio becomes 0.
REQ-034 resetn=0 asserted while out_valid=1 and done=2'b01 -> next cycle out_valid=0, done=0, tuple_count=0, in_ready follows load_ok=1.
REQ-035 Counter wrap with CNT_WIDTH=4 -> 16 accepted tuples without a stream end return tuple_count to 0.
